// File: rtl/vga_timing_decoder_if.sv
// Tapped VGA timing inputs and the recovered coordinate/status outputs of the decoder.
interface vga_timing_decoder_if;
  logic       pixel_clk;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       err_clr;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pix_valid;
  logic       frame_start;
  logic [9:0] line_len;
  logic [9:0] frame_lines;
  logic       h_err;
  logic       v_err;
  logic       locked;

  modport master (
    output pixel_clk, hs, vs, blank, err_clr,
    input  DrawX, DrawY, pix_valid, frame_start, line_len, frame_lines, h_err, v_err, locked
  );

  modport slave (
    input  pixel_clk, hs, vs, blank, err_clr,
    output DrawX, DrawY, pix_valid, frame_start, line_len, frame_lines, h_err, v_err, locked
  );
endinterface

// File: rtl/vga_timing_decoder.sv
// Recovers pixel coordinates, frame strobes and timing-health status from a tapped VGA stream.
module vga_timing_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic                 Clk,
  input logic                 Reset_n,
  vga_timing_decoder_if.slave bus
);

  localparam int unsigned CW = 10;
  localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  state_t          state, state_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic            pixel_clk_q, hs_q, vs_q;
  logic            first_line, first_frame, frame_bad, line_act;
  logic [CW-1:0]   hcnt, vcnt, xact, yact;
  logic            pstb, hfall, vfall, h_mis, v_meas, v_mis, frame_good;
  logic [CW-1:0]   vcnt_inc;

  // Strobe, edge detection and per-event mismatch decode
  always_comb begin
    pstb       = bus.pixel_clk & ~pixel_clk_q;
    hfall      = pstb & hs_q & ~bus.hs;
    vfall      = pstb & vs_q & ~bus.vs;
    h_mis      = hfall & ~first_line & (hcnt != CW'(H_TOTAL));
    vcnt_inc   = (hfall && vcnt != CMAX) ? vcnt + CW'(1) : vcnt;
    v_meas     = vfall & ~first_frame;
    v_mis      = v_meas & (vcnt_inc != CW'(V_TOTAL));
    frame_good = v_meas & ~v_mis & ~frame_bad & ~h_mis;
  end

  // Lock state machine: next state and good-frame count
  always_comb begin
    state_n = state;
    gcnt_n  = gcnt;
    if (v_meas) begin
      if (frame_good) begin
        if (gcnt != GW'(LOCK_FRAMES)) gcnt_n = gcnt + GW'(1);
        if (gcnt_n == GW'(LOCK_FRAMES)) state_n = ST_LOCKED;
      end else begin
        gcnt_n  = '0;
        state_n = ST_UNLOCKED;
      end
    end
    if (h_mis) state_n = ST_UNLOCKED;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_UNLOCKED;
      gcnt       <= '0;
      bus.locked <= 1'b0;
    end else begin
      state      <= state_n;
      gcnt       <= gcnt_n;
      bus.locked <= (state_n == ST_LOCKED);
    end
  end

  // Sticky error flags; a new mismatch beats a simultaneous clear
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.h_err <= 1'b0;
      bus.v_err <= 1'b0;
    end else begin
      if (h_mis)            bus.h_err <= 1'b1;
      else if (bus.err_clr) bus.h_err <= 1'b0;
      if (v_mis)            bus.v_err <= 1'b1;
      else if (bus.err_clr) bus.v_err <= 1'b0;
    end
  end

  // Line/frame measurement and coordinate tracking, advanced only on pixel strobes
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pixel_clk_q     <= 1'b0;
      hs_q            <= 1'b0;
      vs_q            <= 1'b0;
      first_line      <= 1'b1;
      first_frame     <= 1'b1;
      frame_bad       <= 1'b0;
      line_act        <= 1'b0;
      hcnt            <= '0;
      vcnt            <= '0;
      xact            <= '0;
      yact            <= '0;
      bus.DrawX       <= '0;
      bus.DrawY       <= '0;
      bus.pix_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.line_len    <= '0;
      bus.frame_lines <= '0;
    end else begin
      pixel_clk_q     <= bus.pixel_clk;
      bus.pix_valid   <= pstb & bus.blank;
      bus.frame_start <= vfall;
      if (pstb) begin
        hs_q <= bus.hs;
        vs_q <= bus.vs;

        if (hfall) begin
          hcnt       <= CW'(1);
          first_line <= 1'b0;
          if (!first_line) bus.line_len <= hcnt;
        end else if (hcnt != CMAX) begin
          hcnt <= hcnt + CW'(1);
        end

        if (bus.blank) begin
          bus.DrawX <= xact;
          bus.DrawY <= yact;
        end
        if (hfall)                          xact <= '0;
        else if (bus.blank && xact != CMAX) xact <= xact + CW'(1);

        // Row advances only past lines that carried active video
        if (vfall) begin
          yact     <= '0;
          line_act <= 1'b0;
        end else if (hfall) begin
          if (line_act && yact != CMAX) yact <= yact + CW'(1);
          line_act <= 1'b0;
        end else if (bus.blank) begin
          line_act <= 1'b1;
        end

        if (vfall) begin
          vcnt        <= '0;
          first_frame <= 1'b0;
          frame_bad   <= 1'b0;
          if (!first_frame) bus.frame_lines <= vcnt_inc;
        end else begin
          vcnt <= vcnt_inc;
          if (h_mis) frame_bad <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Receive-side counterpart of the VGA timing generator: consumes hs, vs, blank and pixel_clk and recovers pixel coordinates, frame/line strobes and timing-health status.
- Sits beside the VGA output path, tapping the same signals driven to the connector.
- Used for on-board self-check (LEDR/HEX status) and as a coordinate source for capture or overlay logic that cannot reach the generator's DrawX/DrawY directly.

Parameters:
- H_TOTAL, 800, expected pixel-clock periods per line (hs falling edge to next hs falling edge)
- V_TOTAL, 525, expected lines per frame (vs falling edge to next vs falling edge)
- LOCK_FRAMES, 2, consecutive clean frames required before locked asserts

Ports:
- Clk  in  1  system clock (50 MHz); everything is sampled on rising Clk
- Reset_n  in  1  asynchronous, active-low reset
- pixel_clk  in  1  pixel clock, generated synchronously from Clk (toggles at Clk/2)
- hs  in  1  horizontal sync, active low
- vs  in  1  vertical sync, active low
- blank  in  1  1 = active video, 0 = blanking
- err_clr  in  1  one-cycle pulse; clears sticky error flags
- DrawX  out  10  recovered column of the current active pixel
- DrawY  out  10  recovered row of the current active line
- pix_valid  out  1  one-Clk pulse per active pixel; DrawX/DrawY are valid while it is high
- frame_start  out  1  one-Clk pulse on each vs falling edge
- line_len  out  10  last measured line length, in pixel periods
- frame_lines  out  10  last measured frame length, in lines
- h_err  out  1  sticky flag: a measured line length differed from H_TOTAL
- v_err  out  1  sticky flag: a measured frame length differed from V_TOTAL
- locked  out  1  timing has been stable for LOCK_FRAMES frames

Behaviour:
- Reset values: all outputs 0; all internal counters 0; first_line = 1 and first_frame = 1.
- Pixel strobe: pstb = pixel_clk & ~pixel_clk_q. pixel_clk_q is a single register, which is enough because pixel_clk is synchronous to Clk. All hs/vs/blank sampling and all counter updates happen only on Clk cycles where pstb = 1.
- Edge detection: hs_q and vs_q register the previous strobed values.
  - hfall = pstb & hs_q & ~hs
  - vfall = pstb & vs_q & ~vs
- Horizontal measurement:
  - hcnt increments on each pstb and saturates at 1023.
  - On hfall: if first_line = 0, latch line_len = hcnt; if hcnt != H_TOTAL, set h_err. Then hcnt <= 1 and first_line <= 0.
- Active-pixel tracking:
  - xact resets to 0 on hfall.
  - On each pstb with blank = 1, on the same Clk edge: DrawX <= xact, DrawY <= yact, pix_valid <= 1, xact <= xact + 1 (saturating at 1023).
  - Latency is one Clk from the strobe to the outputs. pix_valid is 0 on every other cycle.
- Line tracking:
  - line_act is set by any active pixel in the current line.
  - On hfall: if line_act = 1, yact increments (saturating) and line_act clears.
  - On vfall: yact <= 0 and line_act <= 0.
  - vfall wins over hfall when both occur on the same strobe.
- Vertical measurement:
  - vcnt increments on each hfall and saturates at 1023.
  - On vfall: frame_start pulses for one Clk. If first_frame = 0, latch frame_lines = vcnt; if vcnt != V_TOTAL, set v_err. Then vcnt <= 0 and first_frame <= 0.
  - When hfall and vfall coincide, the hfall increment is applied before the compare.
- Lock state machine:
  - States are UNLOCKED and LOCKED, with a good-frame counter gcnt.
  - On each vfall with first_frame = 0: the frame is good if vcnt == V_TOTAL and no line mismatch occurred during that frame (per-frame flag, cleared at vfall).
  - Good frame: gcnt increments, saturating at LOCK_FRAMES. When gcnt reaches LOCK_FRAMES, go to LOCKED (locked = 1).
  - Bad frame: gcnt <= 0 and go to UNLOCKED.
  - A line mismatch while LOCKED drops locked on the same hfall-driven update.
- Error flags:
  - h_err and v_err stay set until err_clr or reset.
  - err_clr clears both flags. If a new mismatch occurs on the same cycle as err_clr, the set wins.
- Reset mid-operation: asynchronous reset immediately returns every output and counter to its reset value. The first hfall/vfall after release only re-seeds the counters and performs no compare.
- If pixel_clk stops, the block holds all state and raises no errors.

Test Plan:
- Nominal 640x480 stream (800x525, 96-pixel hsync, 2-line vsync) for 3 frames → line_len = 800, frame_lines = 525, locked = 1 at the third vfall, h_err = v_err = 0, and exactly 640×480 = 307200 pix_valid pulses per frame.
- Coordinate recovery in the nominal stream → the first pix_valid after frame_start shows DrawX = 0, DrawY = 0; the last shows DrawX = 639, DrawY = 479, one Clk after its strobe.
- Inject one 799-period line in frame 4 → line_len = 799, h_err = 1 and locked = 0 at that hfall; locked returns at the end of frame 6; h_err stays 1 until an err_clr pulse, then reads 0.
- Frame of 524 lines → frame_lines = 524, v_err = 1, locked = 0, gcnt restarts.
- Reset asserted mid-frame, released at an arbitrary line → all outputs 0 during reset; the first post-reset hfall/vfall raises no error; locked after LOCK_FRAMES full clean frames following the first vfall.
- pixel_clk held low for 1000 Clk mid-line → no pix_valid pulses, counters frozen, no error flags; the stream resumes cleanly.
